switch_alloc: RTL and testbench

- Wormhole switch allocator for the 5-port mesh router.
- Sits between the per-input address generators and the crossbar. Each input's head flit has already been resolved to a requested output port.
- For each output, arbitrates among requesting inputs with round-robin priority, then locks the output to the winner until that packet's tail flit has passed.
- Drives crossbar select, input-queue pop and output-valid signals.

---
 rtl/noc_pkg.sv | 31 +++
 rtl/switch_alloc_rr_arbiter.sv | 35 +++
 rtl/switch_alloc.sv | 115 +++++++++++
 tb/tb_switch_alloc.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
`default_nettype none
// ============================================================================
// Module : noc_pkg
// Brief  : Shared port codes, port count and output-state type for the router.
// Rev    : 1.0 - initial release
// ============================================================================
package noc_pkg;

    localparam int NPORTS = 5;

    typedef logic [2:0] port_t;

    localparam port_t PORT_N    = 3'd0;
    localparam port_t PORT_S    = 3'd1;
    localparam port_t PORT_E    = 3'd2;
    localparam port_t PORT_W    = 3'd3;
    localparam port_t PORT_L    = 3'd4;
    localparam port_t PORT_NONE = 3'd7;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } out_state_t;

    // Round-robin successor over the five valid port codes.
    function automatic port_t next_port(input port_t p);
        return (p >= PORT_L) ? PORT_N : port_t'(p + 3'd1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/switch_alloc_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module : rr_arbiter
// Brief  : Combinational round-robin pick among five requesters from a pointer.
// Rev    : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import noc_pkg::*;
(
    input  logic [NPORTS-1:0] i_req,
    input  port_t             i_ptr,
    output logic [NPORTS-1:0] o_grant,
    output port_t             o_winner
);

    port_t w_idx;
    logic  w_found;

    always_comb begin
        o_grant  = '0;
        o_winner = PORT_NONE;
        w_found  = 1'b0;
        w_idx    = i_ptr;
        for (int i = 0; i < NPORTS; i++) begin
            if (!w_found && i_req[w_idx]) begin
                w_found          = 1'b1;
                o_grant[w_idx]   = 1'b1;
                o_winner         = w_idx;
            end
            w_idx = next_port(w_idx);
        end
    end

endmodule
`default_nettype wire

// File: rtl/switch_alloc.sv
`default_nettype none
// ============================================================================
// Module : switch_alloc
// Brief  : Wormhole switch allocator: per-output round-robin grant and lock.
// Rev    : 1.0 - initial release
// ============================================================================
module switch_alloc
    import noc_pkg::*;
(
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic  [NPORTS-1:0]       valid_i,
    input  port_t [NPORTS-1:0]       req_port_addr_i,
    input  logic  [NPORTS-1:0]       tail_i,
    input  logic  [NPORTS-1:0]       out_ready_i,
    output logic  [NPORTS-1:0]       pop_o,
    output logic  [NPORTS-1:0]       out_valid_o,
    output port_t [NPORTS-1:0]       sel_o,
    output logic  [NPORTS-1:0]       busy_o
);

    out_state_t        r_state  [NPORTS];
    port_t             r_owner  [NPORTS];
    port_t             r_ptr    [NPORTS];
    logic [NPORTS-1:0] r_inlock;

    logic [NPORTS-1:0] w_req    [NPORTS];
    logic [NPORTS-1:0] w_grant  [NPORTS];
    port_t             w_winner [NPORTS];
    logic [NPORTS-1:0] w_release;
    logic [NPORTS-1:0] w_lock_set;
    logic [NPORTS-1:0] w_lock_clr;

    // Request matrix: w_req[o][p]. Codes 5..7 never match any output.
    always_comb begin
        for (int o = 0; o < NPORTS; o++) begin
            w_req[o] = '0;
            for (int p = 0; p < NPORTS; p++) begin
                if (valid_i[p] && (req_port_addr_i[p] == port_t'(o)) && !r_inlock[p]) begin
                    w_req[o][p] = 1'b1;
                end
            end
        end
    end

    for (genvar o = 0; o < NPORTS; o++) begin : g_arb
        rr_arbiter u_arb (
            .i_req    (w_req[o]),
            .i_ptr    (r_ptr[o]),
            .o_grant  (w_grant[o]),
            .o_winner (w_winner[o])
        );
    end

    always_comb begin
        pop_o       = '0;
        out_valid_o = '0;
        busy_o      = '0;
        w_release   = '0;
        w_lock_set  = '0;
        w_lock_clr  = '0;
        for (int o = 0; o < NPORTS; o++) begin
            sel_o[o] = PORT_NONE;
        end
        for (int o = 0; o < NPORTS; o++) begin
            if (r_state[o] == LOCKED) begin
                busy_o[o] = 1'b1;
                sel_o[o]  = r_owner[o];
                if (valid_i[r_owner[o]] && out_ready_i[o]) begin
                    out_valid_o[o]     = 1'b1;
                    pop_o[r_owner[o]]  = 1'b1;
                    if (tail_i[r_owner[o]]) begin
                        w_release[o]           = 1'b1;
                        w_lock_clr[r_owner[o]] = 1'b1;
                    end
                end
            end else begin
                w_lock_set = w_lock_set | w_grant[o];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int o = 0; o < NPORTS; o++) begin
                r_state[o] <= IDLE;
                r_owner[o] <= PORT_N;
                r_ptr[o]   <= PORT_N;
            end
        end else begin
            for (int o = 0; o < NPORTS; o++) begin
                if (r_state[o] == IDLE) begin
                    if (|w_grant[o]) begin
                        r_state[o] <= LOCKED;
                        r_owner[o] <= w_winner[o];
                        r_ptr[o]   <= next_port(w_winner[o]);
                    end
                end else if (w_release[o]) begin
                    r_state[o] <= IDLE;
                end
            end
        end
    end

    // Set and clear never target the same input: a locked input cannot request.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_inlock <= '0;
        end else begin
            r_inlock <= (r_inlock | w_lock_set) & ~w_lock_clr;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_switch_alloc.sv
`default_nettype none
// ============================================================================
// Module : tb_switch_alloc
// Brief  : Directed vector bench for the wormhole switch allocator.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_switch_alloc;

    typedef struct {
        logic [4:0]  valid;
        logic [14:0] addr;
        logic [4:0]  tail;
        logic [4:0]  ready;
        logic [4:0]  pop;
        logic [4:0]  ovld;
        logic [4:0]  busy;
        logic [14:0] sel;
    } vec_t;

    localparam logic [14:0] c_SEL_NONE = 15'h7FFF;

    logic            clk;
    logic            rst_n;
    logic [4:0]      valid;
    logic [4:0][2:0] addr;
    logic [4:0]      tail;
    logic [4:0]      ready;
    logic [4:0]      pop;
    logic [4:0]      ovld;
    logic [4:0][2:0] sel;
    logic [4:0]      busy;

    int n_checks = 0;
    int n_fail   = 0;
    vec_t vecs[$];

    switch_alloc dut (
        .clk_i           (clk),
        .rst_n_i         (rst_n),
        .valid_i         (valid),
        .req_port_addr_i (addr),
        .tail_i          (tail),
        .out_ready_i     (ready),
        .pop_o           (pop),
        .out_valid_o     (ovld),
        .sel_o           (sel),
        .busy_o          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packs five 3-bit fields, index 0 in the least significant bits.
    function automatic logic [14:0] f5(input int a0, input int a1, input int a2,
                                       input int a3, input int a4);
        logic [2:0] b0, b1, b2, b3, b4;
        b0 = 3'(a0); b1 = 3'(a1); b2 = 3'(a2); b3 = 3'(a3); b4 = 3'(a4);
        return {b4, b3, b2, b1, b0};
    endfunction

    function automatic vec_t mkv(input logic [4:0] v, input logic [14:0] a,
                                 input logic [4:0] t, input logic [4:0] r,
                                 input logic [4:0] p, input logic [4:0] ov,
                                 input logic [4:0] b, input logic [14:0] s);
        vec_t x;
        x.valid = v; x.addr = a; x.tail = t; x.ready = r;
        x.pop = p; x.ovld = ov; x.busy = b; x.sel = s;
        return x;
    endfunction

    task automatic chk(input string nm, input int idx,
                       input logic [14:0] act, input logic [14:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %h, expected %h", nm, idx, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int idx, input logic [4:0] p,
                           input logic [4:0] ov, input logic [4:0] b,
                           input logic [14:0] s);
        chk({tag, ".pop"},  idx, 15'(pop),  15'(p));
        chk({tag, ".ovld"}, idx, 15'(ovld), 15'(ov));
        chk({tag, ".busy"}, idx, 15'(busy), 15'(b));
        chk({tag, ".sel"},  idx, sel,       s);
    endtask

    task automatic drive(input logic [4:0] v, input logic [14:0] a,
                         input logic [4:0] t, input logic [4:0] r);
        valid = v; addr = a; tail = t; ready = r;
    endtask

    initial begin
        logic [14:0] a_rr, a_wh, a_par;
        a_rr  = f5(3, 3, 0, 0, 3);
        a_wh  = f5(4, 4, 0, 0, 0);
        a_par = f5(1, 6, 3, 0, 2);

        // Single-flit W -> E
        vecs.push_back(mkv(5'b01000, f5(0,0,0,2,0), 5'b01000, 5'h1F, 5'h00, 5'h00, 5'h00, c_SEL_NONE));
        vecs.push_back(mkv(5'b01000, f5(0,0,0,2,0), 5'b01000, 5'h1F, 5'b01000, 5'b00100, 5'b00100, f5(7,7,3,7,7)));
        vecs.push_back(mkv(5'b00000, f5(0,0,0,2,0), 5'b00000, 5'h1F, 5'h00, 5'h00, 5'h00, c_SEL_NONE));
        // Round robin N, S, L -> W
        for (int k = 0; k < 8; k++) begin
            if (k % 2 == 0)
                vecs.push_back(mkv(5'b10011, a_rr, 5'b10011, 5'h1F, 5'h00, 5'h00, 5'h00, c_SEL_NONE));
            else if (k == 3)
                vecs.push_back(mkv(5'b10011, a_rr, 5'b10011, 5'h1F, 5'b00010, 5'b01000, 5'b01000, f5(7,7,7,1,7)));
            else if (k == 5)
                vecs.push_back(mkv(5'b10011, a_rr, 5'b10011, 5'h1F, 5'b10000, 5'b01000, 5'b01000, f5(7,7,7,4,7)));
            else
                vecs.push_back(mkv(5'b10011, a_rr, 5'b10011, 5'h1F, 5'b00001, 5'b01000, 5'b01000, f5(7,7,7,0,7)));
        end
        vecs.push_back(mkv(5'b00000, a_rr, 5'b00000, 5'h1F, 5'h00, 5'h00, 5'h00, c_SEL_NONE));
        // Wormhole N -> L (4 flits) with S contending, 3-cycle backpressure
        vecs.push_back(mkv(5'b00001, a_wh, 5'b00000, 5'h1F, 5'h00, 5'h00, 5'h00, c_SEL_NONE));
        vecs.push_back(mkv(5'b00001, a_wh, 5'b00000, 5'h1F, 5'b00001, 5'b10000, 5'b10000, f5(7,7,7,7,0)));
        for (int k = 0; k < 2; k++)
            vecs.push_back(mkv(5'b00011, a_wh, 5'b00010, 5'h1F, 5'b00001, 5'b10000, 5'b10000, f5(7,7,7,7,0)));
        for (int k = 0; k < 3; k++)
            vecs.push_back(mkv(5'b00011, a_wh, 5'b00010, 5'h0F, 5'h00, 5'h00, 5'b10000, f5(7,7,7,7,0)));
        vecs.push_back(mkv(5'b00011, a_wh, 5'b00011, 5'h1F, 5'b00001, 5'b10000, 5'b10000, f5(7,7,7,7,0)));
        vecs.push_back(mkv(5'b00010, a_wh, 5'b00010, 5'h1F, 5'h00, 5'h00, 5'h00, c_SEL_NONE));
        vecs.push_back(mkv(5'b00010, a_wh, 5'b00010, 5'h1F, 5'b00010, 5'b10000, 5'b10000, f5(7,7,7,7,1)));
        vecs.push_back(mkv(5'b00000, a_wh, 5'b00000, 5'h1F, 5'h00, 5'h00, 5'h00, c_SEL_NONE));
        // Parallel N->S, E->W, L->E; input S carries invalid code 6
        vecs.push_back(mkv(5'b10111, a_par, 5'b00000, 5'h1F, 5'h00, 5'h00, 5'h00, c_SEL_NONE));
        vecs.push_back(mkv(5'b10111, a_par, 5'b00000, 5'h1F, 5'b10101, 5'b01110, 5'b01110, f5(7,0,4,2,7)));
        vecs.push_back(mkv(5'b10111, a_par, 5'b10101, 5'h1F, 5'b10101, 5'b01110, 5'b01110, f5(7,0,4,2,7)));
        for (int k = 0; k < 2; k++)
            vecs.push_back(mkv(5'b00010, a_par, 5'b00010, 5'h1F, 5'h00, 5'h00, 5'h00, c_SEL_NONE));

        rst_n = 1'b0;
        drive(5'h00, 15'h0, 5'h00, 5'h00);
        #2;
        chk_all("reset", 0, 5'h00, 5'h00, 5'h00, c_SEL_NONE);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            drive(vecs[i].valid, vecs[i].addr, vecs[i].tail, vecs[i].ready);
            #1;
            chk_all("vec", i, vecs[i].pop, vecs[i].ovld, vecs[i].busy, vecs[i].sel);
            @(posedge clk); #1;
        end

        // Reset in the middle of a 3-flit N -> S packet; ptr[1] is 1 beforehand
        drive(5'b00001, f5(1,0,0,0,0), 5'b00000, 5'h1F);
        #1;
        chk_all("rst_seq", 0, 5'h00, 5'h00, 5'h00, c_SEL_NONE);
        @(posedge clk); #1;
        chk_all("rst_seq", 1, 5'b00001, 5'b00010, 5'b00010, f5(7,0,7,7,7));
        @(posedge clk); #1;
        chk_all("rst_seq", 2, 5'b00001, 5'b00010, 5'b00010, f5(7,0,7,7,7));
        #1;
        rst_n = 1'b0;
        #1;
        chk_all("rst_seq", 3, 5'h00, 5'h00, 5'h00, c_SEL_NONE);
        drive(5'h00, 15'h0, 5'h00, 5'h1F);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        drive(5'b00011, f5(1,1,0,0,0), 5'b00011, 5'h1F);
        #1;
        chk_all("rst_seq", 4, 5'h00, 5'h00, 5'h00, c_SEL_NONE);
        @(posedge clk); #1;
        chk_all("rst_seq", 5, 5'b00001, 5'b00010, 5'b00010, f5(7,0,7,7,7));
        @(posedge clk); #1;
        chk_all("rst_seq", 6, 5'h00, 5'h00, 5'h00, c_SEL_NONE);
        @(posedge clk); #1;
        chk_all("rst_seq", 7, 5'b00010, 5'b00010, 5'b00010, f5(7,1,7,7,7));
        drive(5'h00, 15'h0, 5'h00, 5'h1F);
        @(posedge clk); #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
